// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC generator: FSM state encoding,
// PC width, sequential increment and default boot/trap vectors.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] PC_INCR              = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_redirect_sel.sv
// Redirect priority mux (trap > jmp > br > pending) with target alignment check.
// Define PC_COMPRESSED_EN to accept 2-byte aligned jmp/br targets.
module pc_redirect_sel
    import pc_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic                trap,
    input  logic                jmp_valid,
    input  logic [PC_WIDTH-1:0] jmp_target,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                pend_valid,
    input  logic                pend_trap,
    input  logic [PC_WIDTH-1:0] pend_target,
    output logic [PC_WIDTH-1:0] target,
    output logic                valid,
    output logic                misaligned
);

    logic [PC_WIDTH-1:0] raw;
    logic                is_trap;
    logic                checked;
    logic                bad_align;

    always_comb begin
        raw     = '0;
        is_trap = 1'b0;
        checked = 1'b0;
        valid   = 1'b0;
        if (trap) begin
            valid   = 1'b1;
            is_trap = 1'b1;
        end else if (jmp_valid) begin
            valid   = 1'b1;
            raw     = jmp_target;
            checked = 1'b1;
        end else if (br_taken) begin
            valid   = 1'b1;
            raw     = br_target;
            checked = 1'b1;
        end else if (pend_valid) begin
            valid = 1'b1;
            if (pend_trap) begin
                is_trap = 1'b1;
            end else begin
                raw     = pend_target;
                checked = 1'b1;
            end
        end
    end

`ifdef PC_COMPRESSED_EN
    assign bad_align = raw[0];
`else
    assign bad_align = |raw[1:0];
`endif

    // Trap vectors are always aligned; only jmp/br-derived addresses are checked.
    assign misaligned = checked & bad_align;
    assign target     = (is_trap || misaligned) ? TRAP_VECTOR : raw;

endmodule

// File: rtl/pc_next_gen.sv
// Next-PC generator: BOOT/RUN/HOLD FSM holding the PC while fetch is stalled,
// with a pending redirect register. Alignment rule selected by PC_COMPRESSED_EN.
module pc_next_gen
    import pc_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_next,
    input  logic                stall,
    input  logic                imem_ready,
    input  logic                trap,
    input  logic                jmp_valid,
    input  logic [PC_WIDTH-1:0] jmp_target,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_target,
    output logic                fetch_valid,
    output logic                misalign_err
);

    pc_state_t           state;
    logic                pend_valid;
    logic                pend_trap;
    logic [PC_WIDTH-1:0] pend_target;

    logic                advance;
    logic                live_valid;
    logic [PC_WIDTH-1:0] live_target;
    logic [PC_WIDTH-1:0] sel_target;
    logic                sel_valid;
    logic                sel_misaligned;

    assign advance     = !stall && imem_ready;
    assign live_valid  = trap || jmp_valid || br_taken;
    assign live_target = jmp_valid ? jmp_target : br_target;

    // Pending is only a candidate while holding; in RUN it is always clear.
    pc_redirect_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_sel (
        .trap        (trap),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pend_valid  (pend_valid && (state == ST_HOLD)),
        .pend_trap   (pend_trap),
        .pend_target (pend_target),
        .target      (sel_target),
        .valid       (sel_valid),
        .misaligned  (sel_misaligned)
    );

    always_comb begin
        pc_next      = pc;
        misalign_err = 1'b0;
        case (state)
            ST_BOOT: pc_next = RESET_VECTOR;
            ST_RUN, ST_HOLD: begin
                if (advance) begin
                    if (sel_valid) begin
                        pc_next      = sel_target;
                        misalign_err = sel_misaligned;
                    end else begin
                        pc_next = pc + PC_INCR;
                    end
                end
            end
            default: pc_next = RESET_VECTOR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            fetch_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_trap   <= 1'b0;
            pend_target <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (!advance) begin
                        state <= ST_HOLD;
                        if (live_valid) begin
                            pend_valid  <= 1'b1;
                            pend_trap   <= trap;
                            pend_target <= live_target;
                        end
                    end
                end
                ST_HOLD: begin
                    if (advance) begin
                        state      <= ST_RUN;
                        pend_valid <= 1'b0;
                        pend_trap  <= 1'b0;
                    end else if (live_valid && !pend_trap) begin
                        // A latched trap is sticky; anything else is overwritten.
                        pend_valid  <= 1'b1;
                        pend_trap   <= trap;
                        pend_target <= live_target;
                    end
                end
                default: begin
                    state       <= ST_BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
